dzcpu_ucode_seq: RTL and testbench
==================================

// Module: dzcpu_ucode_seq
// PURPOSE
//  Micro-program sequencer for the dzcpu core. Owns the micro-PC (uPC) that addresses the ucode ROM.
//  Loads flow entry points from the opcode LUT and CB-prefix LUT, and steps or stalls the flow.
//  Resolves unconditional and Z-conditional end-of-flow; arbitrates the five GB interrupt sources at instruction boundaries.
//  Sits between the fetch/memory unit and dzcpu_ucode_rom; the LUTs and ROM stay outside this block.
// PARAMETERS
//  UPC_W         8       width of uPC / ROM address
//  INT_FLOW_IDX  8'd167  ucode flow entry used for interrupt dispatch (push PC, jump to vector)
//  NUM_INT       5       interrupt sources: 0=VBlank 1=LCDSTAT 2=Timer 3=Serial 4=Joypad
// PORTS
//  iClock         in   1        core clock; all state updates on rising edge
//  iReset_n       in   1        asynchronous reset, active low
//  iMopValid      in   1        fetched mOp byte valid this cycle (FETCH state only)
//  iLutIdx        in   UPC_W    flow index from dzcpu_ucode_lut for current mOp
//  iCbLutIdx      in   UPC_W    flow index from dzcpu_ucode_cblut for CB-suffix byte
//  iStall         in   1        memory wait; freezes uPC and state
//  iEof           in   1        decoded uop carries unconditional eof
//  iEofZ          in   1        decoded uop ends flow if Z=1
//  iEofNz         in   1        decoded uop ends flow if Z=0
//  iJcb           in   1        decoded uop redirects to CB flow
//  iFlagZ         in   1        current Z flag
//  iEi / iDi      in   1        EI / DI executed (set / clear IME)
//  iIE / iIF      in   NUM_INT  interrupt enable / request registers
//  oUopAddr       out  UPC_W    ucode ROM address (= uPC)
//  oFetchReq      out  1        high in FETCH: fetch unit presents next mOp
//  oIntAck        out  NUM_INT  one-hot one-cycle pulse: clear that IF bit
//  oIntVector     out  8        dispatch vector low byte (0x40+8*n), held until next dispatch
//  oIme           out  1        interrupt master enable
// BEHAVIOUR
//  Reset: uPC=0, state=FETCH, oFetchReq=1, oIntAck=0, oIntVector=0, oIme=0. Asynchronous assert, synchronous release.
//  States: FETCH, EXEC, INT. iStall=1 holds every register except IME updates.
//  FETCH: on iMopValid, uPC<=iLutIdx (0 selects generic 1-byte flow) -> EXEC. Otherwise hold.
//  EXEC: end = iEof | (iEofZ&iFlagZ) | (iEofNz&~iFlagZ). Priority per cycle:
//    end > iJcb > increment.
//    end: -> INT if (IME & |(iIE&iIF)), else -> FETCH. uPC<=0 on the FETCH path.
//    iJcb: uPC<=iCbLutIdx (same cycle the CB byte is presented); stay EXEC.
//    otherwise uPC<=uPC+1. Wrap 255->0 permitted, not flagged.
//  INT: winner = lowest set bit of iIE&iIF. Effects in one cycle:
//    oIntAck pulses that bit; oIntVector<=8'h40+8*n; IME<=0; uPC<=INT_FLOW_IDX -> EXEC.
//  Pending set empty on INT entry (IF cleared by software between cycles): -> FETCH, no ack.
//  IME: iDi clears, iEi sets; both asserted -> DI wins. IME sampled only at end-of-flow; EI effective from next boundary.
//  Interrupts never preempt mid-flow; uPC path latency from LUT to oUopAddr is 1 cycle.
//  Reset mid-flow: discards flow; no ack issued.
// CONFIGURATION
//  DZCPU_INT_EN defined: INT state, arbiter, oIntAck/oIntVector/oIme as above.
//  Undefined: end-of-flow always -> FETCH; oIntAck=0, oIntVector=0, oIme=0 constant; iEi/iDi/iIE/iIF ignored.
// STRUCTURE
//  Shared package/header dzcpu_defs: state encodings, INT vector base 8'h40, source bit positions, FLOW_ID_INT.
//  Sub-module dzcpu_int_arbiter: combinational fixed-priority pick plus registered ack/vector. Instantiated only under DZCPU_INT_EN.
// TESTING
//  1. Reset low mid-EXEC at uPC=50 -> uPC=0, FETCH, oIme=0, oIntAck=0 immediately, before next clock edge.
//  2. iLutIdx=1, iMopValid -> oUopAddr 1,2,3,4. iEof at 4 -> FETCH, uPC=0. iStall 3 cycles at uPC=2 holds 2.
//  3. iLutIdx=13, iJcb at uPC=15 with iCbLutIdx=16 -> uPC=16; iEof -> FETCH.
//  4. iLutIdx=17, iEofZ at 19: Z=1 -> FETCH after 19. Z=0 -> 20,21,22, then eof.
//  5. IME=1, iIE=5'b00101, iIF=5'b00101, eof -> INT; oIntAck=00001, vector 0x40, uPC=167, IME=0.
//  6. iEi&iDi same cycle -> IME=0. IME=1 but iIE&iIF=0 at eof -> FETCH, no ack. Build without DZCPU_INT_EN -> ack never pulses.

Source files
------------

// File: rtl/dzcpu_defs_pkg.sv
// Shared definitions for the dzcpu micro-sequencer: state encoding,
// interrupt vector base, interrupt source bit positions, and interrupt flow id.
package dzcpu_defs;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_INT   = 2'd2
   } seq_state_e;

   localparam logic [7:0] INT_VEC_BASE = 8'h40;
   localparam logic [7:0] FLOW_ID_INT  = 8'd167;

   localparam int unsigned INT_SRC_VBLANK  = 0;
   localparam int unsigned INT_SRC_LCDSTAT = 1;
   localparam int unsigned INT_SRC_TIMER   = 2;
   localparam int unsigned INT_SRC_SERIAL  = 3;
   localparam int unsigned INT_SRC_JOYPAD  = 4;

   // Vector low byte for interrupt source n: 0x40 + 8*n
   function automatic logic [7:0] int_vector(input logic [2:0] n);
      return INT_VEC_BASE + {2'b00, n, 3'b000};
   endfunction

endpackage

// File: rtl/dzcpu_int_arbiter.sv
// Fixed-priority interrupt arbiter: the lowest pending source wins.
// The acknowledge is a one-cycle registered pulse; the vector is held until the next dispatch.
module dzcpu_int_arbiter
   import dzcpu_defs::*;
#(
   parameter int unsigned NUM_INT = 5
) (
   input  logic               iClock,
   input  logic               iReset_n,
   input  logic [NUM_INT-1:0] iPending,
   input  logic               iDispatch,
   output logic               oAny,
   output logic [NUM_INT-1:0] oIntAck,
   output logic [7:0]         oIntVector
);

   logic [NUM_INT-1:0] pick_oh;
   logic [2:0]         pick_idx;
   logic [NUM_INT-1:0] ack_q, ack_d;
   logic [7:0]         vec_q, vec_d;

   assign oAny = |iPending;

   // Priority pick: scan from the highest source down so the lowest set bit is kept last
   always_comb begin
      pick_oh  = '0;
      pick_idx = '0;
      for (int unsigned i = NUM_INT; i > 0; i--) begin
         if (iPending[i-1]) begin
            pick_oh        = '0;
            pick_oh[i-1]   = 1'b1;
            pick_idx       = 3'(i - 1);
         end
      end
   end

   // Ack pulses only on a dispatch cycle; vector is updated on dispatch and otherwise held
   always_comb begin
      ack_d = '0;
      vec_d = vec_q;
      if (iDispatch) begin
         ack_d = pick_oh;
         vec_d = int_vector(pick_idx);
      end
   end

   // Ack/vector registers
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         ack_q <= '0;
         vec_q <= '0;
      end else begin
         ack_q <= ack_d;
         vec_q <= vec_d;
      end
   end

   assign oIntAck    = ack_q;
   assign oIntVector = vec_q;

endmodule

// File: rtl/dzcpu_ucode_seq.sv
// Micro-program sequencer for the dzcpu core: owns the uPC addressing the ucode ROM,
// loads flow entry points from the opcode/CB LUTs, and resolves end-of-flow.
// Interrupt dispatch (INT state, arbiter, IME) is built only when DZCPU_INT_EN is defined.
module dzcpu_ucode_seq
   import dzcpu_defs::*;
#(
   parameter int unsigned          UPC_W        = 8,
   parameter logic [UPC_W-1:0]     INT_FLOW_IDX = UPC_W'(FLOW_ID_INT),
   parameter int unsigned          NUM_INT      = 5
) (
   input  logic               iClock,
   input  logic               iReset_n,
   input  logic               iMopValid,
   input  logic [UPC_W-1:0]   iLutIdx,
   input  logic [UPC_W-1:0]   iCbLutIdx,
   input  logic               iStall,
   input  logic               iEof,
   input  logic               iEofZ,
   input  logic               iEofNz,
   input  logic               iJcb,
   input  logic               iFlagZ,
   input  logic               iEi,
   input  logic               iDi,
   input  logic [NUM_INT-1:0] iIE,
   input  logic [NUM_INT-1:0] iIF,
   output logic [UPC_W-1:0]   oUopAddr,
   output logic               oFetchReq,
   output logic [NUM_INT-1:0] oIntAck,
   output logic [7:0]         oIntVector,
   output logic               oIme
);

   seq_state_e       state_q, state_d;
   logic [UPC_W-1:0] upc_q, upc_d;
   logic             flow_end;

   assign flow_end = iEof | (iEofZ & iFlagZ) | (iEofNz & ~iFlagZ);

`ifdef DZCPU_INT_EN
   logic dispatch;
   logic int_any;
   logic ime_q, ime_d;

   dzcpu_int_arbiter #(
      .NUM_INT (NUM_INT)
   ) u_int_arbiter (
      .iClock     (iClock),
      .iReset_n   (iReset_n),
      .iPending   (iIE & iIF),
      .iDispatch  (dispatch),
      .oAny       (int_any),
      .oIntAck    (oIntAck),
      .oIntVector (oIntVector)
   );

   // IME: EI sets, DI overrides EI, dispatch clears; updates even while stalled
   always_comb begin
      ime_d = ime_q;
      if (iEi)      ime_d = 1'b1;
      if (iDi)      ime_d = 1'b0;
      if (dispatch) ime_d = 1'b0;
   end

   // IME register
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) ime_q <= 1'b0;
      else           ime_q <= ime_d;
   end

   assign oIme = ime_q;
`else
   logic unused_int_inputs;
   assign unused_int_inputs = ^{iEi, iDi, iIE, iIF};
   assign oIntAck    = '0;
   assign oIntVector = '0;
   assign oIme       = 1'b0;
`endif

   // Next-state and next-uPC; stall freezes both
   always_comb begin
      state_d = state_q;
      upc_d   = upc_q;
`ifdef DZCPU_INT_EN
      dispatch = 1'b0;
`endif
      if (!iStall) begin
         case (state_q)
            ST_FETCH: begin
               if (iMopValid) begin
                  upc_d   = iLutIdx;
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (flow_end) begin
`ifdef DZCPU_INT_EN
                  if (ime_q && int_any) begin
                     state_d = ST_INT;
                  end else begin
                     state_d = ST_FETCH;
                     upc_d   = '0;
                  end
`else
                  state_d = ST_FETCH;
                  upc_d   = '0;
`endif
               end else if (iJcb) begin
                  upc_d = iCbLutIdx;
               end else begin
                  upc_d = upc_q + UPC_W'(1);
               end
            end
            default: begin
               // Pending set may have been cleared by software since the boundary
`ifdef DZCPU_INT_EN
               if (int_any) begin
                  dispatch = 1'b1;
                  upc_d    = INT_FLOW_IDX;
                  state_d  = ST_EXEC;
               end else begin
                  state_d = ST_FETCH;
                  upc_d   = '0;
               end
`else
               state_d = ST_FETCH;
               upc_d   = '0;
`endif
            end
         endcase
      end
   end

   // State and uPC registers
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q <= ST_FETCH;
         upc_q   <= '0;
      end else begin
         state_q <= state_d;
         upc_q   <= upc_d;
      end
   end

   assign oUopAddr  = upc_q;
   assign oFetchReq = (state_q == ST_FETCH);

endmodule

// File: tb/tb_dzcpu_ucode_seq.sv
// Self-checking bench for dzcpu_ucode_seq: directed scenarios plus randomized
// stimulus compared each cycle against a behavioural model. Honors DZCPU_INT_EN.
module tb_dzcpu_ucode_seq;

`ifdef DZCPU_INT_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif

   logic       iClock = 1'b0;
   logic       iReset_n;
   logic       iMopValid;
   logic [7:0] iLutIdx, iCbLutIdx;
   logic       iStall, iEof, iEofZ, iEofNz, iJcb, iFlagZ, iEi, iDi;
   logic [4:0] iIE, iIF;
   logic [7:0] oUopAddr;
   logic       oFetchReq;
   logic [4:0] oIntAck;
   logic [7:0] oIntVector;
   logic       oIme;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Model: phase 0 = waiting for an opcode, 1 = running a flow, 2 = interrupt pending dispatch
   int         m_phase;
   int         m_upc;
   bit         m_ime;
   logic [4:0] m_ack;
   logic [7:0] m_vec;

   always #5 iClock = ~iClock;

   dzcpu_ucode_seq #(
      .UPC_W        (8),
      .INT_FLOW_IDX (8'd167),
      .NUM_INT      (5)
   ) dut (
      .iClock     (iClock),
      .iReset_n   (iReset_n),
      .iMopValid  (iMopValid),
      .iLutIdx    (iLutIdx),
      .iCbLutIdx  (iCbLutIdx),
      .iStall     (iStall),
      .iEof       (iEof),
      .iEofZ      (iEofZ),
      .iEofNz     (iEofNz),
      .iJcb       (iJcb),
      .iFlagZ     (iFlagZ),
      .iEi        (iEi),
      .iDi        (iDi),
      .iIE        (iIE),
      .iIF        (iIF),
      .oUopAddr   (oUopAddr),
      .oFetchReq  (oFetchReq),
      .oIntAck    (oIntAck),
      .oIntVector (oIntVector),
      .oIme       (oIme)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_upc   = 0;
      m_ime   = 1'b0;
      m_ack   = '0;
      m_vec   = '0;
   endtask

   task automatic model_step();
      logic [4:0] p;
      bit         fin;
      bit         disp;
      int         n;
      disp  = 1'b0;
      m_ack = '0;
      p     = iIE & iIF;
      if (!iStall) begin
         if (m_phase == 0) begin
            if (iMopValid) begin
               m_upc   = iLutIdx;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            fin = iEof || (iEofZ && iFlagZ) || (iEofNz && !iFlagZ);
            if (fin) begin
               if (INT_EN && m_ime && p != 0) begin
                  m_phase = 2;
               end else begin
                  m_phase = 0;
                  m_upc   = 0;
               end
            end else if (iJcb) begin
               m_upc = iCbLutIdx;
            end else begin
               m_upc = (m_upc + 1) % 256;
            end
         end else begin
            if (p != 0) begin
               n = 0;
               for (int i = 4; i >= 0; i--) if (p[i]) n = i;
               m_ack   = 5'(1 << n);
               m_vec   = 8'(64 + 8 * n);
               m_upc   = 167;
               m_phase = 1;
               disp    = 1'b1;
            end else begin
               m_phase = 0;
               m_upc   = 0;
            end
         end
      end
      if (INT_EN) begin
         if (iEi) m_ime = 1'b1;
         if (iDi) m_ime = 1'b0;
         if (disp) m_ime = 1'b0;
      end
   endtask

   task automatic compare_all();
      chk("upc",    32'(oUopAddr),   32'(m_upc));
      chk("fetch",  32'(oFetchReq),  32'(m_phase == 0));
      chk("ack",    32'(oIntAck),    32'(m_ack));
      chk("vector", 32'(oIntVector), 32'(m_vec));
      chk("ime",    32'(oIme),       32'(m_ime));
   endtask

   task automatic idle();
      iMopValid = 0; iLutIdx = '0; iCbLutIdx = '0; iStall = 0;
      iEof = 0; iEofZ = 0; iEofNz = 0; iJcb = 0; iFlagZ = 0;
      iEi = 0; iDi = 0; iIE = '0; iIF = '0;
   endtask

   // One clock: model advances on the same edge as the DUT, outputs compared at the falling edge
   task automatic tick();
      @(posedge iClock);
      model_step();
      @(negedge iClock);
      compare_all();
   endtask

   task automatic load(input logic [7:0] idx);
      idle();
      iMopValid = 1; iLutIdx = idx;
      tick();
      idle();
   endtask

   initial begin
      idle();
      iReset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge iClock);
      iReset_n = 1'b1;
      compare_all();
      chk("reset_fetchreq", 32'(oFetchReq), 32'd1);

      // Reset asserted mid-flow takes effect without a clock edge
      iEi = 1; tick(); idle();
      load(8'd50);
      chk("t1_upc50", 32'(oUopAddr), 32'd50);
      #2 iReset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("t1_async_upc", 32'(oUopAddr), 32'd0);
      @(negedge iClock);
      iReset_n = 1'b1;

      // Linear flow with stall and unconditional eof
      load(8'd1);
      chk("t2_first", 32'(oUopAddr), 32'd1);
      tick();
      iStall = 1; repeat (3) tick(); iStall = 0;
      chk("t2_stall_hold", 32'(oUopAddr), 32'd2);
      tick(); tick();
      chk("t2_at4", 32'(oUopAddr), 32'd4);
      iEof = 1; tick(); idle();
      chk("t2_eof_fetch", 32'(oFetchReq), 32'd1);

      // CB redirect
      load(8'd13); tick(); tick();
      iJcb = 1; iCbLutIdx = 8'd16; tick(); idle();
      chk("t3_cb", 32'(oUopAddr), 32'd16);
      iEof = 1; tick(); idle();

      // Z-conditional eof, both polarities
      load(8'd17); tick(); tick();
      iEofZ = 1; iFlagZ = 1; tick(); idle();
      chk("t4_z1_end", 32'(oUopAddr), 32'd0);
      load(8'd17); tick(); tick();
      iEofZ = 1; iFlagZ = 0; tick(); idle();
      tick(); tick();
      chk("t4_z0_run", 32'(oUopAddr), 32'd22);
      iEof = 1; tick(); idle();

      // Interrupt dispatch at an instruction boundary
      iEi = 1; tick(); idle();
      load(8'd5);
      iEof = 1; iIE = 5'b00101; iIF = 5'b00101; tick();
      idle(); iIE = 5'b00101; iIF = 5'b00101; tick(); idle();
`ifdef DZCPU_INT_EN
      chk("t5_ack",    32'(oIntAck),    32'h01);
      chk("t5_vector", 32'(oIntVector), 32'h40);
      chk("t5_upc",    32'(oUopAddr),   32'd167);
      chk("t5_ime",    32'(oIme),       32'd0);
`else
      chk("t5_noack",  32'(oIntAck),    32'h00);
`endif
      tick();
      iEof = 1; tick(); idle();

      // EI+DI together, and IME set with nothing pending
      iEi = 1; tick(); iDi = 1; tick(); idle();
      chk("t6_di_wins", 32'(oIme), 32'd0);
      iEi = 1; tick(); idle();
      load(8'd9);
      iEof = 1; iIE = 5'b00001; iIF = 5'b00010; tick(); idle();
      chk("t6_no_pend_fetch", 32'(oFetchReq), 32'd1);
      chk("t6_no_pend_ack",   32'(oIntAck),   32'd0);

      // Randomized traffic
      for (int k = 0; k < 2000; k++) begin
         iMopValid = ($urandom_range(1, 0) == 1);
         iLutIdx   = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 250)) : 8'($urandom);
         iCbLutIdx = 8'($urandom);
         iStall    = ($urandom_range(5, 0) == 0);
         iEof      = ($urandom_range(7, 0) == 0);
         iEofZ     = ($urandom_range(7, 0) == 0);
         iEofNz    = ($urandom_range(7, 0) == 0);
         iJcb      = ($urandom_range(9, 0) == 0);
         iFlagZ    = 1'($urandom);
         iEi       = ($urandom_range(5, 0) == 0);
         iDi       = ($urandom_range(9, 0) == 0);
         iIE       = 5'($urandom);
         iIF       = ($urandom_range(2, 0) == 0) ? 5'($urandom) : 5'b0;
         tick();
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
